// File: rtl/mmu_arbiter.sv
// Arbiter for the core's instruction-read, data-read and data-write channels onto one
// single-port memory bus; requests are batched, served W > DR > IR, and reads returned registered.
module mmu_arbiter #(
  parameter bit ALIGN = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        INST_RDEN,
  input  logic [31:0] INST_RIADDR,
  output logic [31:0] INST_ROADDR,
  output logic        INST_RVALID,
  output logic [31:0] INST_RDATA,
  input  logic        DATA_RDEN,
  input  logic [31:0] DATA_RIADDR,
  output logic [31:0] DATA_ROADDR,
  output logic        DATA_RVALID,
  output logic [31:0] DATA_RDATA,
  input  logic        DATA_WREN,
  input  logic [31:0] DATA_WADDR,
  input  logic [31:0] DATA_WDATA,
  output logic        MEM_WAIT,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic        MEM_ACK,
  input  logic [31:0] MEM_RDATA
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Slot vectors are ordered {W, DR, IR} so bit position doubles as priority.
  localparam logic [2:0] SEL_W  = 3'b100;
  localparam logic [2:0] SEL_DR = 3'b010;
  localparam logic [2:0] SEL_IR = 3'b001;

  function automatic logic [31:0] bus_addr(input logic [31:0] a);
    if (ALIGN) bus_addr = {a[31:2], 2'b00};
    else       bus_addr = a;
  endfunction

  state_t      state_r;
  logic [2:0]  pend_r;
  logic [2:0]  cur_r;
  logic [31:0] w_addr_r, w_data_r, dr_addr_r, ir_addr_r;
  logic [31:0] inst_stage_r, data_stage_r;
  logic        inst_served_r, data_served_r;
  logic        mem_wait_r, mem_req_r, mem_we_r;
  logic [31:0] mem_addr_r, mem_wdata_r;
  logic        inst_rvalid_r, data_rvalid_r;
  logic [31:0] inst_roaddr_r, inst_rdata_r, data_roaddr_r, data_rdata_r;

  logic        capture_s, ack_s;
  logic [2:0]  pend_nxt_s, sel_s;
  logic [31:0] waddr_s, wdata_s, draddr_s, iraddr_s, sel_addr_s;
  logic [31:0] inst_stage_nxt_s, data_stage_nxt_s;
  logic        inst_served_nxt_s, data_served_nxt_s;

  // Next pending set (fresh batch or remainder after an ack) and the slot to put on the bus.
  always_comb begin
    capture_s = (state_r == IDLE) && (INST_RDEN || DATA_RDEN || DATA_WREN);
    ack_s     = (state_r == BUSY) && mem_req_r && MEM_ACK;
    if (capture_s) begin
      pend_nxt_s = {DATA_WREN, DATA_RDEN, INST_RDEN};
      waddr_s    = DATA_WADDR;
      wdata_s    = DATA_WDATA;
      draddr_s   = DATA_RIADDR;
      iraddr_s   = INST_RIADDR;
    end else begin
      pend_nxt_s = ack_s ? (pend_r & ~cur_r) : pend_r;
      waddr_s    = w_addr_r;
      wdata_s    = w_data_r;
      draddr_s   = dr_addr_r;
      iraddr_s   = ir_addr_r;
    end
    if (pend_nxt_s[2]) begin
      sel_s      = SEL_W;
      sel_addr_s = waddr_s;
    end else if (pend_nxt_s[1]) begin
      sel_s      = SEL_DR;
      sel_addr_s = draddr_s;
    end else if (pend_nxt_s[0]) begin
      sel_s      = SEL_IR;
      sel_addr_s = iraddr_s;
    end else begin
      sel_s      = 3'b000;
      sel_addr_s = 32'h0000_0000;
    end
    if (ack_s && (cur_r == SEL_IR)) begin
      inst_stage_nxt_s  = MEM_RDATA;
      inst_served_nxt_s = 1'b1;
    end else begin
      inst_stage_nxt_s  = inst_stage_r;
      inst_served_nxt_s = inst_served_r;
    end
    if (ack_s && (cur_r == SEL_DR)) begin
      data_stage_nxt_s  = MEM_RDATA;
      data_served_nxt_s = 1'b1;
    end else begin
      data_stage_nxt_s  = data_stage_r;
      data_served_nxt_s = data_served_r;
    end
  end

  // Batch FSM with registered bus and return outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r       <= IDLE;
      pend_r        <= 3'b000;
      cur_r         <= 3'b000;
      w_addr_r      <= 32'h0000_0000;
      w_data_r      <= 32'h0000_0000;
      dr_addr_r     <= 32'h0000_0000;
      ir_addr_r     <= 32'h0000_0000;
      inst_stage_r  <= 32'h0000_0000;
      data_stage_r  <= 32'h0000_0000;
      inst_served_r <= 1'b0;
      data_served_r <= 1'b0;
      mem_wait_r    <= 1'b0;
      mem_req_r     <= 1'b0;
      mem_we_r      <= 1'b0;
      mem_addr_r    <= 32'h0000_0000;
      mem_wdata_r   <= 32'h0000_0000;
      inst_rvalid_r <= 1'b0;
      data_rvalid_r <= 1'b0;
      inst_roaddr_r <= 32'h0000_0000;
      inst_rdata_r  <= 32'h0000_0000;
      data_roaddr_r <= 32'h0000_0000;
      data_rdata_r  <= 32'h0000_0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (capture_s) begin
            state_r       <= BUSY;
            mem_wait_r    <= 1'b1;
            pend_r        <= pend_nxt_s;
            w_addr_r      <= waddr_s;
            w_data_r      <= wdata_s;
            dr_addr_r     <= draddr_s;
            ir_addr_r     <= iraddr_s;
            inst_served_r <= 1'b0;
            data_served_r <= 1'b0;
            inst_rvalid_r <= 1'b0;
            data_rvalid_r <= 1'b0;
            cur_r         <= sel_s;
            mem_req_r     <= 1'b1;
            mem_we_r      <= sel_s[2];
            mem_addr_r    <= bus_addr(sel_addr_s);
            mem_wdata_r   <= wdata_s;
          end
        end
        BUSY: begin
          if (ack_s) begin
            pend_r        <= pend_nxt_s;
            inst_stage_r  <= inst_stage_nxt_s;
            data_stage_r  <= data_stage_nxt_s;
            inst_served_r <= inst_served_nxt_s;
            data_served_r <= data_served_nxt_s;
            if (|pend_nxt_s) begin
              cur_r      <= sel_s;
              mem_we_r   <= sel_s[2];
              mem_addr_r <= bus_addr(sel_addr_s);
            end else begin
              // Batch complete: release the core and publish every read served in it.
              state_r    <= IDLE;
              mem_wait_r <= 1'b0;
              mem_req_r  <= 1'b0;
              cur_r      <= 3'b000;
              if (inst_served_nxt_s) begin
                inst_rvalid_r <= 1'b1;
                inst_roaddr_r <= ir_addr_r;
                inst_rdata_r  <= inst_stage_nxt_s;
              end
              if (data_served_nxt_s) begin
                data_rvalid_r <= 1'b1;
                data_roaddr_r <= dr_addr_r;
                data_rdata_r  <= data_stage_nxt_s;
              end
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          mem_wait_r <= 1'b0;
          mem_req_r  <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_WAIT    = mem_wait_r;
  assign MEM_REQ     = mem_req_r;
  assign MEM_WE      = mem_we_r;
  assign MEM_ADDR    = mem_addr_r;
  assign MEM_WDATA   = mem_wdata_r;
  assign INST_RVALID = inst_rvalid_r;
  assign INST_ROADDR = inst_roaddr_r;
  assign INST_RDATA  = inst_rdata_r;
  assign DATA_RVALID = data_rvalid_r;
  assign DATA_ROADDR = data_roaddr_r;
  assign DATA_RDATA  = data_rdata_r;

endmodule

// File: tb/tb_mmu_arbiter.sv
// Self-checking bench for mmu_arbiter: table-driven batches against a memory model,
// expected bus transfers queued at stimulus time, plus hand-written reset and idle-ack sequences.
module tb_mmu_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic        INST_RDEN, DATA_RDEN, DATA_WREN;
  logic [31:0] INST_RIADDR, DATA_RIADDR, DATA_WADDR, DATA_WDATA;
  logic [31:0] INST_ROADDR, INST_RDATA, DATA_ROADDR, DATA_RDATA;
  logic        INST_RVALID, DATA_RVALID;
  logic        MEM_WAIT, MEM_REQ, MEM_WE, MEM_ACK;
  logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;

  mmu_arbiter #(.ALIGN(1'b1)) dut (
    .CLK(CLK), .RST(RST),
    .INST_RDEN(INST_RDEN), .INST_RIADDR(INST_RIADDR), .INST_ROADDR(INST_ROADDR),
    .INST_RVALID(INST_RVALID), .INST_RDATA(INST_RDATA),
    .DATA_RDEN(DATA_RDEN), .DATA_RIADDR(DATA_RIADDR), .DATA_ROADDR(DATA_ROADDR),
    .DATA_RVALID(DATA_RVALID), .DATA_RDATA(DATA_RDATA),
    .DATA_WREN(DATA_WREN), .DATA_WADDR(DATA_WADDR), .DATA_WDATA(DATA_WDATA),
    .MEM_WAIT(MEM_WAIT), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK), .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  typedef struct {
    logic        w, dr, ir;
    logic [31:0] waddr, wdata, draddr, iraddr;
    int          wait_cfg;
    bit          noise;
    int          exp_wait;
    logic        ev_i;
    logic [31:0] ea_i, ed_i;
    logic        ev_d;
    logic [31:0] ea_d, ed_d;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bus_t exp_q[$];
  vec_t vecs[8];

  logic [31:0] mem [logic [31:0]];
  bit          mem_en   = 1'b0;
  int          wait_cfg = 0;
  int          wcnt     = 0;
  logic        auto_ack = 1'b0;
  logic        man_ack  = 1'b0;

  assign MEM_ACK = mem_en ? auto_ack : man_ack;

  // Memory model: acks after wait_cfg extra REQ cycles, commits writes at ack.
  always @(posedge CLK) begin
    #1;
    auto_ack = 1'b0;
    if (mem_en && MEM_REQ) begin
      if (wcnt == wait_cfg) begin
        auto_ack = 1'b1;
        wcnt = 0;
        if (MEM_WE) mem[MEM_ADDR] = MEM_WDATA;
        else        MEM_RDATA = mem.exists(MEM_ADDR) ? mem[MEM_ADDR] : 32'h0000_0000;
      end else begin
        wcnt = wcnt + 1;
      end
    end else begin
      wcnt = 0;
    end
  end

  function automatic logic [31:0] al(input logic [31:0] a);
    al = {a[31:2], 2'b00};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    INST_RDEN = 1'b0; DATA_RDEN = 1'b0; DATA_WREN = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   cyc;
    int   wcount;
    bit   done;
    bus_t b;
    wait_cfg = v.wait_cfg;
    mem_en   = 1'b1;
    @(negedge CLK);
    DATA_WREN = v.w;  DATA_WADDR = v.waddr;  DATA_WDATA = v.wdata;
    DATA_RDEN = v.dr; DATA_RIADDR = v.draddr;
    INST_RDEN = v.ir; INST_RIADDR = v.iraddr;
    if (v.w)  exp_q.push_back('{1'b1, al(v.waddr), v.wdata});
    if (v.dr) exp_q.push_back('{1'b0, al(v.draddr), 32'h0000_0000});
    if (v.ir) exp_q.push_back('{1'b0, al(v.iraddr), 32'h0000_0000});
    @(posedge CLK);
    cyc = 0; wcount = 0; done = 1'b0;
    while (!done) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 1) begin
        clear_reqs();
        if (v.noise) begin
          INST_RDEN = 1'b1; INST_RIADDR = 32'h0000_0008;
          DATA_WREN = 1'b1; DATA_WADDR = 32'h0000_0600; DATA_WDATA = 32'hDEAD_0000;
        end
      end
      if (MEM_WAIT) wcount++;
      if (MEM_REQ) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL v%0d_bus_unexpected: transfer we=%0b addr=0x%08h with none pending", idx, MEM_WE, MEM_ADDR);
        end else begin
          b = exp_q[0];
          chk($sformatf("v%0d_bus_we", idx), {31'd0, MEM_WE}, {31'd0, b.we});
          chk($sformatf("v%0d_bus_addr", idx), MEM_ADDR, b.addr);
          if (b.we) chk($sformatf("v%0d_bus_wdata", idx), MEM_WDATA, b.wdata);
          if (MEM_ACK) void'(exp_q.pop_front());
        end
      end
      if (!MEM_WAIT) done = 1'b1;
      else if (cyc > 60) begin
        checks++; errors++;
        $display("FAIL v%0d_timeout: MEM_WAIT still high after %0d cycles", idx, cyc);
        done = 1'b1;
      end
    end
    clear_reqs();
    chk($sformatf("v%0d_wait_cycles", idx), wcount, v.exp_wait);
    chk($sformatf("v%0d_req_low", idx), {31'd0, MEM_REQ}, 32'd0);
    chk($sformatf("v%0d_pending_left", idx), exp_q.size(), 32'd0);
    exp_q.delete();
    chk($sformatf("v%0d_inst_rvalid", idx), {31'd0, INST_RVALID}, {31'd0, v.ev_i});
    if (v.ev_i) begin
      chk($sformatf("v%0d_inst_roaddr", idx), INST_ROADDR, v.ea_i);
      chk($sformatf("v%0d_inst_rdata", idx), INST_RDATA, v.ed_i);
    end
    chk($sformatf("v%0d_data_rvalid", idx), {31'd0, DATA_RVALID}, {31'd0, v.ev_d});
    if (v.ev_d) begin
      chk($sformatf("v%0d_data_roaddr", idx), DATA_ROADDR, v.ea_d);
      chk($sformatf("v%0d_data_rdata", idx), DATA_RDATA, v.ed_d);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wait"}, {31'd0, MEM_WAIT}, 32'd0);
    chk({tag, "_req"}, {31'd0, MEM_REQ}, 32'd0);
    chk({tag, "_we"}, {31'd0, MEM_WE}, 32'd0);
    chk({tag, "_addr"}, MEM_ADDR, 32'd0);
    chk({tag, "_wdata"}, MEM_WDATA, 32'd0);
    chk({tag, "_ivalid"}, {31'd0, INST_RVALID}, 32'd0);
    chk({tag, "_dvalid"}, {31'd0, DATA_RVALID}, 32'd0);
    chk({tag, "_iroaddr"}, INST_ROADDR, 32'd0);
    chk({tag, "_irdata"}, INST_RDATA, 32'd0);
    chk({tag, "_droaddr"}, DATA_ROADDR, 32'd0);
    chk({tag, "_drdata"}, DATA_RDATA, 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    clear_reqs();
    INST_RIADDR = 32'd0; DATA_RIADDR = 32'd0; DATA_WADDR = 32'd0; DATA_WDATA = 32'd0;
    MEM_RDATA = 32'd0;
    mem[32'h0000_0104] = 32'h0010_0093;
    mem[32'h0000_0008] = 32'h0000_0013;
    mem[32'h0000_0200] = 32'h1111_1111;
    mem[32'h0000_0300] = 32'h1234_5678;
    mem[32'h0000_0400] = 32'hCAFE_F00D;

    //          w     dr    ir    waddr          wdata          draddr         iraddr         wc noise exp ev_i  ea_i           ed_i           ev_d  ea_d           ed_d
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0,         32'h0,         32'h0,         32'h0000_0104, 0, 1'b0, 1, 1'b1, 32'h0000_0104, 32'h0010_0093, 1'b0, 32'h0,         32'h0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 32'h0000_0200, 32'h0000_0008, 0, 1'b0, 3, 1'b1, 32'h0000_0008, 32'h0000_0013, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0000_0203, 32'h0,         0, 1'b0, 1, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0203, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0000_0300, 32'h0,         3, 1'b0, 4, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0300, 32'h1234_5678};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0BAD_F00D, 32'h0,         32'h0,         1, 1'b0, 2, 1'b0, 32'h0,         32'h0,         1'b0, 32'h0,         32'h0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h0,         32'h0000_0500, 32'h0000_0400, 2, 1'b0, 6, 1'b1, 32'h0000_0400, 32'hCAFE_F00D, 1'b1, 32'h0000_0500, 32'h0BAD_F00D};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 32'h0,         32'h0,         32'h0000_0300, 32'h0,         2, 1'b1, 3, 1'b0, 32'h0,         32'h0,         1'b1, 32'h0000_0300, 32'h1234_5678};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h0,         32'h0,         32'h0000_0104, 32'h0000_0008, 0, 1'b0, 2, 1'b1, 32'h0000_0008, 32'h0000_0013, 1'b1, 32'h0000_0104, 32'h0010_0093};

    repeat (2) @(negedge CLK);
    chk_reset_outputs("reset");
    RST = 1'b0;
    @(negedge CLK);
    chk("post_reset_req", {31'd0, MEM_REQ}, 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // MEM_ACK while idle must not start a transfer or disturb the returned reads.
    mem_en = 1'b0;
    @(negedge CLK);
    man_ack = 1'b1;
    @(negedge CLK);
    chk("idle_ack_req", {31'd0, MEM_REQ}, 32'd0);
    chk("idle_ack_wait", {31'd0, MEM_WAIT}, 32'd0);
    @(negedge CLK);
    man_ack = 1'b0;
    chk("idle_ack_ivalid", {31'd0, INST_RVALID}, 32'd1);
    chk("idle_ack_irdata", INST_RDATA, 32'h0000_0013);
    chk("idle_ack_dvalid", {31'd0, DATA_RVALID}, 32'd1);
    chk("idle_ack_droaddr", DATA_ROADDR, 32'h0000_0104);
    chk("idle_ack_drdata", DATA_RDATA, 32'h0010_0093);

    // Reset in the second REQ cycle of a read that the memory never acks in time.
    @(negedge CLK);
    DATA_RDEN = 1'b1; DATA_RIADDR = 32'h0000_0300;
    @(negedge CLK);
    clear_reqs();
    chk("rst_seq_req1", {31'd0, MEM_REQ}, 32'd1);
    chk("rst_seq_addr1", MEM_ADDR, 32'h0000_0300);
    @(negedge CLK);
    chk("rst_seq_req2", {31'd0, MEM_REQ}, 32'd1);
    RST = 1'b1;
    #1;
    chk_reset_outputs("rst_async");
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    man_ack = 1'b1;
    MEM_RDATA = 32'hBAD0_BAD0;
    @(negedge CLK);
    man_ack = 1'b0;
    repeat (2) begin
      @(negedge CLK);
      chk("late_ack_req", {31'd0, MEM_REQ}, 32'd0);
      chk("late_ack_wait", {31'd0, MEM_WAIT}, 32'd0);
      chk("late_ack_dvalid", {31'd0, DATA_RVALID}, 32'd0);
      chk("late_ack_drdata", DATA_RDATA, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmu_arbiter.md
# mmu_arbiter

Memory-side companion of the core that serves the core's three memory channels (instruction read, data read, data write) over one shared single-port memory bus, and generates the core's MEM_WAIT hazard signal. It sits directly downstream of the core's INST_*/DATA_* ports and upstream of the system memory. Requests are captured in a batch, issued one at a time in fixed priority, and read results are returned in registered form.

## Interface
- ALIGN, default 1: when 1, MEM_ADDR[1:0] is forced to 0; when 0, the address passes through unchanged.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous and active-high.
- INST_RDEN  in  1  instruction read request.
- INST_RIADDR  in  32  instruction read address.
- INST_ROADDR  out  32  address belonging to INST_RDATA.
- INST_RVALID  out  1  INST_RDATA/INST_ROADDR are valid.
- INST_RDATA  out  32  instruction word.
- DATA_RDEN  in  1  data read request.
- DATA_RIADDR  in  32  data read address.
- DATA_ROADDR  out  32  address belonging to DATA_RDATA.
- DATA_RVALID  out  1  DATA_RDATA/DATA_ROADDR are valid.
- DATA_RDATA  out  32  data word.
- DATA_WREN  in  1  data write request.
- DATA_WADDR  in  32  write address.
- DATA_WDATA  in  32  write data, full word.
- MEM_WAIT  out  1  arbiter busy; the core holds its pipeline while this is high.
- MEM_REQ  out  1  bus request, registered.
- MEM_WE  out  1  1 = write, 0 = read. Valid while MEM_REQ is high.
- MEM_ADDR  out  32  bus address.
- MEM_WDATA  out  32  bus write data.
- MEM_ACK  in  1  transfer done. Sampled only while MEM_REQ is high.
- MEM_RDATA  in  32  read data. Valid in the cycle MEM_ACK is high on a read.

## Operation
- Two states: IDLE and BUSY. MEM_WAIT = (state == BUSY), driven directly from a flop.
- Capture (IDLE, any of INST_RDEN/DATA_RDEN/DATA_WREN high):
  - Latch each request's enable, address and write data into a pending slot: one slot each for W, DR and IR.
  - Clear INST_RVALID and DATA_RVALID.
  - Go to BUSY.
  - Drive MEM_REQ=1 for the highest-priority pending slot at the same edge.
- Priority is fixed: W > DR > IR. Write before read means a same-batch read of the write address returns the new data.
- BUSY:
  - MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA hold stable until MEM_ACK.
  - On an edge with MEM_ACK high:
    - Clear the served slot.
    - On a read, store MEM_RDATA into the staging register for that channel.
    - If any slot remains, drive MEM_REQ for the next slot at the same edge (back-to-back, no idle cycle).
    - If no slot remains, set MEM_REQ=0 and return to IDLE. At that same edge, load the RDATA/ROADDR outputs from the staging registers and set RVALID for every read channel served in the batch.
- ROADDR returns the unmasked captured request address, not MEM_ADDR.
- RVALID and the data outputs hold until the next capture edge.
- Requests arriving while BUSY are ignored; the core must hold them until MEM_WAIT falls.
- MEM_ACK while MEM_REQ is low is ignored. MEM_RDATA on a write ack is ignored.
- IDLE with no request: no state change; RVALID outputs hold.

## Timing
- Reset (asynchronous) values: state IDLE, MEM_WAIT 0, MEM_REQ 0, MEM_WE 0, MEM_ADDR 0, MEM_WDATA 0, all RVALID 0, all ROADDR/RDATA 0, all pending slots clear.
- RST asserted mid-transfer:
  - The in-flight transfer is abandoned and not replayed.
  - A late MEM_ACK after release is ignored, because MEM_REQ=0.
- Capture in cycle N: MEM_REQ high from N+1.
- With k transfers that each ack in their first REQ cycle:
  - MEM_WAIT is high for cycles N+1 .. N+k.
  - MEM_WAIT falls and RVALID rises at N+k+1.
- Each cycle MEM_ACK is delayed adds one cycle.
- Minimum single-read latency: request at N, data at N+2.

## Test plan
- Single IR at 0x0000_0104, zero-wait memory returning 0x0010_0093:
  - MEM_REQ=1, MEM_WE=0, MEM_ADDR=0x104 at N+1.
  - MEM_WAIT high only at N+1.
  - At N+2: INST_RVALID=1, INST_ROADDR=0x104, INST_RDATA=0x0010_0093.
- W(0x200, 0xDEAD_BEEF) + DR(0x200) + IR(0x8) in one cycle:
  - Bus order is W, DR, IR on N+1, N+2, N+3.
  - DATA_RDATA=0xDEAD_BEEF.
  - MEM_WAIT high N+1..N+3; both RVALIDs high at N+4.
- Memory acks after 3 wait cycles:
  - MEM_ADDR and MEM_WE stay stable all 4 REQ cycles.
  - MEM_WAIT high 4 cycles.
- ALIGN=1, DR at 0x0000_0203:
  - MEM_ADDR=0x200; DATA_ROADDR=0x203.
- RST pulsed in the second REQ cycle of a delayed read:
  - All outputs go to reset values immediately.
  - An ack 1 cycle after release causes no RVALID.
- MEM_ACK pulsed while IDLE, and requests asserted while BUSY:
  - No bus transfer.
  - No change to the pending slots or outputs.
